// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and defaults
// for the T1000 TDC shot sequencer.
package tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int START_W_DEF = 4;
  localparam int TRIG_W_DEF  = 2;
  localparam int GAP_CYC_DEF = 16;
  localparam int TMO_CYC_DEF = 1024;
  localparam int DLY_W_DEF   = 10;
  localparam int SHOT_W_DEF  = 8;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tdc_shot_seq_if.sv
// tdc_shot_seq_if: host-side request
// and status bundle of the shot sequencer.
interface tdc_shot_seq_if
  import tdc_pkg::*;
#(
  parameter int DLY_W  = DLY_W_DEF,
  parameter int SHOT_W = SHOT_W_DEF
);
  logic              meas_req;
  logic [SHOT_W-1:0] shot_num;
  logic              cal_en;
  logic [DLY_W-1:0]  cal_dly;
  logic              busy;
  logic              shot_done;
  logic              shot_hit;
  logic [SHOT_W-1:0] hit_cnt;
  logic              meas_done;

  modport master (
    output meas_req, shot_num, cal_en, cal_dly,
    input  busy, shot_done, shot_hit,
    input  hit_cnt, meas_done
  );

  modport slave (
    input  meas_req, shot_num, cal_en, cal_dly,
    output busy, shot_done, shot_hit,
    output hit_cnt, meas_done
  );
endinterface

// File: rtl/tdc_shot_seq.sv
// tdc_shot_seq: start/wait/gap shot sequencer
// with optional calibration trigger loop.
module tdc_shot_seq
  import tdc_pkg::*;
#(
  parameter int START_W = START_W_DEF,
  parameter int TRIG_W  = TRIG_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int DLY_W   = DLY_W_DEF,
  parameter int SHOT_W  = SHOT_W_DEF
) (
  input  logic            clk5,
  input  logic            rst_n,
  tdc_shot_seq_if.slave   ctl,
  input  logic            coarse_tri,
  input  logic            overflow,
  output logic            TDC_start,
  output logic            TDC_trigger
);

  localparam int CMAX = max3(START_W, GAP_CYC, TMO_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int EW   = ((CW > DLY_W) ? CW : DLY_W) + 2;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [SHOT_W-1:0] rem;
  logic              cal_q;
  logic [DLY_W-1:0]  dly_q;

  logic          hit;
  logic          miss;
  logic          fin;
  logic          in_win;
  logic [EW-1:0] wc;
  logic [EW-1:0] lo;
  logic [EW-1:0] hi;

  assign hit  = coarse_tri;
  assign miss = overflow || (cnt == CW'(TMO_CYC - 1));
  assign fin  = hit || miss;

  assign wc = EW'(cnt);
  assign lo = EW'(dly_q);
  assign hi = lo + EW'(TRIG_W);
  assign in_win = cal_q && (wc >= lo) && (wc < hi);

  // single FSM; cnt is the phase counter
  // shared by START, WAIT and GAP
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rem           <= '0;
      cal_q         <= 1'b0;
      dly_q         <= '0;
      TDC_start     <= 1'b0;
      TDC_trigger   <= 1'b0;
      ctl.busy      <= 1'b0;
      ctl.shot_done <= 1'b0;
      ctl.shot_hit  <= 1'b0;
      ctl.hit_cnt   <= '0;
      ctl.meas_done <= 1'b0;
    end else begin
      ctl.shot_done <= 1'b0;
      ctl.meas_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ctl.meas_req) begin
            cal_q       <= ctl.cal_en;
            dly_q       <= ctl.cal_dly;
            rem         <= (ctl.shot_num == '0) ?
                           SHOT_W'(1) : ctl.shot_num;
            ctl.hit_cnt <= '0;
            ctl.busy    <= 1'b1;
            cnt         <= '0;
            TDC_start   <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          if (cnt == CW'(START_W - 1)) begin
            cnt       <= '0;
            TDC_start <= 1'b0;
            state     <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (fin) begin
            ctl.shot_done <= 1'b1;
            ctl.shot_hit  <= hit;
            if (hit && !(&ctl.hit_cnt))
              ctl.hit_cnt <= ctl.hit_cnt + SHOT_W'(1);
            rem         <= rem - SHOT_W'(1);
            cnt         <= '0;
            TDC_trigger <= 1'b0;
            state       <= S_GAP;
          end else begin
            cnt         <= cnt + CW'(1);
            TDC_trigger <= in_win;
          end
        end
        S_GAP: begin
          if (cnt == CW'(GAP_CYC - 1)) begin
            cnt <= '0;
            if (rem != '0) begin
              TDC_start <= 1'b1;
              state     <= S_START;
            end else begin
              ctl.meas_done <= 1'b1;
              state         <= S_DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          ctl.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_shot_seq.sv
// tb_tdc_shot_seq: directed scoreboard bench
// for the TDC shot sequencer.
module tb_tdc_shot_seq;
  import tdc_pkg::*;

  localparam int SW  = 4;
  localparam int TW  = 2;
  localparam int GC  = 16;
  localparam int TMO = 1024;

  logic clk5 = 1'b0;
  logic rst_n = 1'b0;
  logic coarse_tri = 1'b0;
  logic overflow = 1'b0;
  logic TDC_start;
  logic TDC_trigger;

  tdc_shot_seq_if #(.DLY_W(10), .SHOT_W(8)) ctl ();

  tdc_shot_seq #(
    .START_W(SW), .TRIG_W(TW), .GAP_CYC(GC),
    .TMO_CYC(TMO), .DLY_W(10), .SHOT_W(8)
  ) dut (
    .clk5(clk5),
    .rst_n(rst_n),
    .ctl(ctl),
    .coarse_tri(coarse_tri),
    .overflow(overflow),
    .TDC_start(TDC_start),
    .TDC_trigger(TDC_trigger)
  );

  always #5 clk5 = ~clk5;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int mdone_cnt = 0;
  int exp_cnt = 0;
  logic [8:0] sb[$];
  logic [8:0] e_m;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // scoreboard: pop expectation on each shot end
  always @(negedge clk5) begin
    if (rst_n && ctl.shot_done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e_m = sb.pop_front();
        chk("shot_hit", 32'(ctl.shot_hit), 32'(e_m[8]));
        chk("hit_cnt", 32'(ctl.hit_cnt), 32'(e_m[7:0]));
      end
    end
    if (rst_n && ctl.meas_done === 1'b1) mdone_cnt++;
  end

  task automatic req(input int n, input bit cal,
                     input int dly);
    @(negedge clk5);
    ctl.meas_req = 1'b1;
    ctl.shot_num = 8'(n);
    ctl.cal_en   = cal;
    ctl.cal_dly  = 10'(dly);
    exp_cnt   = 0;
    done_cnt  = 0;
    mdone_cnt = 0;
    @(negedge clk5);
    ctl.meas_req = 1'b0;
    chk("busy_req", 32'(ctl.busy), 1);
    chk("start_req", 32'(TDC_start), 1);
  endtask

  task automatic shot(input int ev, input bit ct,
                      input bit ov, input bit eh,
                      output int tf, output int tl);
    int n;
    int len;
    tf = -1;
    tl = 0;
    n = 0;
    while (TDC_start !== 1'b1 && n < 400) begin
      @(negedge clk5);
      n++;
    end
    if (TDC_start !== 1'b1) begin
      chk("start_timeout", 0, 1);
      return;
    end
    len = 0;
    while (TDC_start === 1'b1 && len < 50) begin
      @(negedge clk5);
      len++;
    end
    chk("start_len", 32'(len), 32'(SW));
    if (eh && exp_cnt != 255) exp_cnt++;
    sb.push_back({eh, 8'(exp_cnt)});
    if (ev >= 0) begin
      for (int i = 1; i <= ev; i++) begin
        @(negedge clk5);
        if (TDC_trigger === 1'b1) begin
          if (tf < 0) tf = i;
          tl++;
        end
      end
      coarse_tri = ct;
      overflow   = ov;
      @(negedge clk5);
      chk("done_lat", 32'(ctl.shot_done), 1);
      coarse_tri = 1'b0;
      overflow   = 1'b0;
    end else begin
      n = 0;
      while (ctl.shot_done !== 1'b1 && n < TMO + 10) begin
        @(negedge clk5);
        n++;
        if (TDC_trigger === 1'b1) tl++;
      end
      chk("tmo_at", 32'(n), 32'(TMO));
    end
  endtask

  task automatic end_meas(input int nshots);
    int n;
    n = 0;
    while (ctl.meas_done !== 1'b1 && n < 100) begin
      @(negedge clk5);
      n++;
    end
    chk("mdone_seen", 32'(ctl.meas_done), 1);
    chk("nshots", 32'(done_cnt), 32'(nshots));
    chk("hit_cnt_end", 32'(ctl.hit_cnt), 32'(exp_cnt));
    @(negedge clk5);
    chk("busy_end", 32'(ctl.busy), 0);
    chk("mdone_pulse", 32'(ctl.meas_done), 0);
    chk("mdone_cnt", 32'(mdone_cnt), 1);
    chk("start_idle", 32'(TDC_start), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tf;
    int tl;
    int n;
    ctl.meas_req = 1'b0;
    ctl.shot_num = '0;
    ctl.cal_en   = 1'b0;
    ctl.cal_dly  = '0;

    repeat (3) @(negedge clk5);
    chk("rst_outs", 32'({TDC_start, TDC_trigger,
        ctl.busy, ctl.shot_done, ctl.shot_hit,
        ctl.hit_cnt, ctl.meas_done}), 0);
    rst_n = 1'b1;
    @(negedge clk5);
    chk("idle_busy", 32'(ctl.busy), 0);

    req(3, 1'b0, 0);
    for (int s = 0; s < 3; s++) begin
      shot(5, 1'b1, 1'b0, 1'b1, tf, tl);
      chk("no_trig", 32'(tl), 0);
    end
    end_meas(3);

    req(1, 1'b1, 20);
    shot(22, 1'b1, 1'b0, 1'b1, tf, tl);
    chk("trig_first", 32'(tf), 21);
    chk("trig_len", 32'(tl), 32'(TW));
    @(negedge clk5);
    chk("trig_off", 32'(TDC_trigger), 0);
    end_meas(1);

    req(1, 1'b0, 0);
    shot(7, 1'b0, 1'b1, 1'b0, tf, tl);
    end_meas(1);

    req(1, 1'b0, 0);
    shot(-1, 1'b0, 1'b0, 1'b0, tf, tl);
    end_meas(1);

    req(1, 1'b0, 0);
    shot(3, 1'b1, 1'b1, 1'b1, tf, tl);
    end_meas(1);

    req(2, 1'b0, 0);
    shot(4, 1'b1, 1'b0, 1'b1, tf, tl);
    ctl.meas_req = 1'b1;
    ctl.shot_num = 8'd5;
    @(negedge clk5);
    ctl.meas_req = 1'b0;
    chk("busy_gap", 32'(ctl.busy), 1);
    shot(4, 1'b1, 1'b0, 1'b1, tf, tl);
    end_meas(2);
    repeat (30) @(negedge clk5);
    chk("no_requeue", 32'(ctl.busy), 0);

    req(0, 1'b0, 0);
    shot(2, 1'b1, 1'b0, 1'b1, tf, tl);
    end_meas(1);

    req(1, 1'b1, 1023);
    shot(-1, 1'b0, 1'b0, 1'b0, tf, tl);
    chk("cal_oor_trig", 32'(tl), 0);
    end_meas(1);

    req(255, 1'b0, 0);
    for (int s = 0; s < 255; s++)
      shot(0, 1'b1, 1'b0, 1'b1, tf, tl);
    end_meas(255);
    chk("hit_sat", 32'(ctl.hit_cnt), 255);

    req(1, 1'b1, 3);
    n = 0;
    while (TDC_trigger !== 1'b1 && n < 40) begin
      @(negedge clk5);
      n++;
    end
    chk("trig_pre_rst", 32'(TDC_trigger), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({TDC_start, TDC_trigger,
        ctl.busy, ctl.shot_done, ctl.shot_hit,
        ctl.hit_cnt, ctl.meas_done}), 0);
    @(negedge clk5);
    rst_n = 1'b1;
    @(negedge clk5);
    chk("rst_no_mdone", 32'(mdone_cnt), 0);

    req(1, 1'b0, 0);
    shot(5, 1'b1, 1'b0, 1'b1, tf, tl);
    end_meas(1);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
